key_match_arbiter: RTL and testbench

- Parametrised successor to the single-channel rotating-key acknowledger.
- NUM_CH requesters each present a key; an internal down-counter sweeps the key space.
- Among requesters whose key equals the current counter value, one is granted per cycle, round-robin, with a registered ack (no combinational req->ack path).
- Per-channel saturating wait counters flag starvation.
- Sits between request sources and a shared resource slot scheduler.

---
 rtl/key_arb_pkg.sv | 13 +
 rtl/key_match_arbiter_rr_pick.sv | 36 +++
 rtl/key_match_arbiter.sv | 132 +++++++++++++
 tb/tb_key_match_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_arb_pkg.sv
// Shared constants and helpers for the key-matching round-robin arbiter.
package key_arb_pkg;

  localparam int NUM_CH_DEFAULT = 4;
  localparam int KEY_W_DEFAULT  = 4;
  localparam int WAIT_W_DEFAULT = 6;

  // Width of a channel index; never narrower than one bit.
  function automatic int idWidth(input int numCh);
    return (numCh > 1) ? $clog2(numCh) : 1;
  endfunction

endpackage

// File: rtl/key_match_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, circularly.
// ptr_i is expected to stay below NUM_CH; NUM_CH need not be a power of two.
module rr_pick
  import key_arb_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEFAULT,
  parameter int ID_W   = idWidth(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [ID_W-1:0]   ptr_i,
  output logic [ID_W-1:0]   winner_o,
  output logic              found_o
);

  // Walk the channels starting at the pointer and keep the first requester seen.
  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    winner_o = '0;
    found_o  = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      sum = {1'b0, ptr_i} + (ID_W+1)'(off);
      if (sum >= (ID_W+1)'(NUM_CH)) begin
        sum = sum - (ID_W+1)'(NUM_CH);
      end
      idx = sum[ID_W-1:0];
      if (!found_o && req_i[idx]) begin
        found_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/key_match_arbiter.sv
// Multi-channel rotating-key acknowledger: a down-counter sweeps the key space and
// channels whose key matches it are granted one per cycle, round-robin, with a
// registered one-hot ack. Per-channel saturating wait counters flag starvation.
module key_match_arbiter
  import key_arb_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEFAULT,
  parameter int KEY_W  = KEY_W_DEFAULT,
  parameter int WAIT_W = WAIT_W_DEFAULT,
  localparam int ID_W  = idWidth(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH*KEY_W-1:0] req_key,
  output logic [NUM_CH-1:0]       ack,
  output logic                    ack_valid,
  output logic [ID_W-1:0]         ack_id,
  output logic [KEY_W-1:0]        cur_key,
  output logic [NUM_CH-1:0]       timeout
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;
  localparam logic [ID_W-1:0]   LAST_CH  = ID_W'(NUM_CH - 1);

  logic [KEY_W-1:0]  curKey_q, curKey_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic              ackValid_q, ackValid_d;
  logic [ID_W-1:0]   ackId_q, ackId_d;
  logic [ID_W-1:0]   rrPtr_q, rrPtr_d;
  logic [WAIT_W-1:0] wait_q [NUM_CH];
  logic [WAIT_W-1:0] wait_d [NUM_CH];

  logic [NUM_CH-1:0] match;
  logic [ID_W-1:0]   winner;
  logic              found;

  // A channel matches when its key equals the pre-advance sweep value and it was not acked this cycle.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      match[i] = req[i] && (req_key[i*KEY_W +: KEY_W] == curKey_q) && !ack_q[i];
    end
  end

  rr_pick #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_rr_pick (
    .req_i    (match),
    .ptr_i    (rrPtr_q),
    .winner_o (winner),
    .found_o  (found)
  );

  // Next sweep value, grant and pointer; losers are simply dropped until the key comes round again.
  always_comb begin
    curKey_d   = en ? (curKey_q - KEY_W'(1)) : curKey_q;
    ack_d      = '0;
    ackValid_d = found;
    ackId_d    = '0;
    rrPtr_d    = rrPtr_q;
    if (found) begin
      ack_d[winner] = 1'b1;
      ackId_d       = winner;
      rrPtr_d       = (winner == LAST_CH) ? '0 : (winner + ID_W'(1));
    end
  end

  // Wait counters clear on idle or grant (clear wins) and otherwise count up to saturation.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wait_d[i] = wait_q[i];
      if (!req[i] || ack_q[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != WAIT_MAX) begin
        wait_d[i] = wait_q[i] + WAIT_W'(1);
      end
    end
  end

  // Starvation flag comes straight from the saturated counter register.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      timeout[i] = (wait_q[i] == WAIT_MAX);
    end
  end

  // Sweep counter starts at all-ones so the first enabled edge walks downward from the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curKey_q <= '1;
    end else begin
      curKey_q <= curKey_d;
    end
  end

  // Grant outputs and round-robin pointer are registered so there is no req-to-ack combinational path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q      <= '0;
      ackValid_q <= 1'b0;
      ackId_q    <= '0;
      rrPtr_q    <= '0;
    end else begin
      ack_q      <= ack_d;
      ackValid_q <= ackValid_d;
      ackId_q    <= ackId_d;
      rrPtr_q    <= rrPtr_d;
    end
  end

  // Per-channel wait counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        wait_q[i] <= wait_d[i];
      end
    end
  end

  assign ack       = ack_q;
  assign ack_valid = ackValid_q;
  assign ack_id    = ackId_q;
  assign cur_key   = curKey_q;

endmodule

// File: tb/tb_key_match_arbiter.sv
// Scoreboard bench for key_match_arbiter: directed scenarios plus random traffic,
// each cycle's expected outputs come from a behavioural model and are queued for a
// separate monitor that compares them after every clock edge.
module tb_key_match_arbiter;

  localparam int NCH = 4;
  localparam int KW  = 4;
  localparam int WW  = 6;
  localparam int WAIT_MAX = (1 << WW) - 1;
  localparam int KEY_MAX  = (1 << KW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [NCH-1:0]  req;
  logic [NCH*KW-1:0] req_key;
  logic [NCH-1:0]  ack;
  logic            ack_valid;
  logic [1:0]      ack_id;
  logic [KW-1:0]   cur_key;
  logic [NCH-1:0]  timeout;

  typedef struct {
    logic [3:0] ack;
    logic       valid;
    logic [1:0] id;
    logic [3:0] key;
    logic [3:0] tmo;
  } exp_t;

  exp_t scb[$];
  int   checks   = 0;
  int   failures = 0;

  // Behavioural model state
  int mKey;
  int mRr;
  int mAckCh;
  int mWait[NCH];

  always #5 clk = ~clk;

  key_match_arbiter #(
    .NUM_CH (NCH),
    .KEY_W  (KW),
    .WAIT_W (WW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .req_key   (req_key),
    .ack       (ack),
    .ack_valid (ack_valid),
    .ack_id    (ack_id),
    .cur_key   (cur_key),
    .timeout   (timeout)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int keyOf(input int c);
    return int'(req_key[c*KW +: KW]);
  endfunction

  task automatic modelReset();
    mKey   = KEY_MAX;
    mRr    = 0;
    mAckCh = -1;
    for (int i = 0; i < NCH; i++) mWait[i] = 0;
  endtask

  // Predict the outputs after the coming edge, queue them, advance the model, then wait one cycle.
  task automatic applyStimulus();
    exp_t e;
    int   win;
    int   c;
    win = -1;
    for (int k = 0; k < NCH; k++) begin
      c = (mRr + k) % NCH;
      if (win < 0 && req[c] && keyOf(c) == mKey && c != mAckCh) win = c;
    end
    for (int i = 0; i < NCH; i++) begin
      if (!req[i] || i == mAckCh) mWait[i] = 0;
      else if (mWait[i] < WAIT_MAX) mWait[i] = mWait[i] + 1;
    end
    if (en) mKey = (mKey == 0) ? KEY_MAX : mKey - 1;
    e.ack   = (win >= 0) ? 4'(1 << win) : 4'h0;
    e.valid = (win >= 0);
    e.id    = (win >= 0) ? 2'(win) : 2'd0;
    e.key   = 4'(mKey);
    for (int i = 0; i < NCH; i++) e.tmo[i] = (mWait[i] == WAIT_MAX);
    scb.push_back(e);
    mAckCh = win;
    if (win >= 0) mRr = (win + 1) % NCH;
    @(negedge clk);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge arrives.
  task automatic applyReset();
    rst_n = 1'b0;
    #1;
    scb.delete();
    modelReset();
    checkOutput("rst_ack", ack, 0);
    checkOutput("rst_ack_valid", ack_valid, 0);
    checkOutput("rst_ack_id", ack_id, 0);
    checkOutput("rst_timeout", timeout, 0);
    checkOutput("rst_cur_key", cur_key, 4'hF);
    @(negedge clk);
    en      = 1'b0;
    req     = '0;
    req_key = '0;
    rst_n   = 1'b1;
  endtask

  // Monitor: compare every queued expectation shortly after the edge it belongs to.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (scb.size() > 0) begin
        e = scb.pop_front();
        checkOutput("mon_ack", ack, e.ack);
        checkOutput("mon_ack_valid", ack_valid, e.valid);
        checkOutput("mon_ack_id", ack_id, e.id);
        checkOutput("mon_cur_key", cur_key, e.key);
        checkOutput("mon_timeout", timeout, e.tmo);
      end
    end
  end

  initial begin
    int ackCyc[$];
    int ackIds[$];
    int n;
    rst_n   = 1'b0;
    en      = 1'b0;
    req     = '0;
    req_key = '0;
    modelReset();
    @(negedge clk);
    applyReset();

    // Single hit: ch1 key C, acked in cycle 4 only
    en = 1'b1;
    req[1] = 1'b1;
    req_key[7:4] = 4'hC;
    repeat (3) applyStimulus();
    checkOutput("hit_key_c", cur_key, 4'hC);
    checkOutput("hit_no_early_ack", ack, 0);
    applyStimulus();
    checkOutput("hit_ack", ack, 4'b0010);
    checkOutput("hit_id", ack_id, 1);
    req[1] = 1'b0;
    applyStimulus();
    checkOutput("hit_pulse", ack, 0);
    applyReset();

    // Contention: ch0 and ch2 on key A
    en = 1'b1;
    req = 4'b0101;
    req_key[3:0]  = 4'hA;
    req_key[11:8] = 4'hA;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      applyStimulus();
      if (ack_valid) begin
        ackCyc.push_back(cyc);
        ackIds.push_back(int'(ack_id));
        req[ack_id] = 1'b0;
      end
    end
    checkOutput("cont_count", ackIds.size(), 2);
    if (ackIds.size() >= 2) begin
      checkOutput("cont_first_id", ackIds[0], 0);
      checkOutput("cont_first_cyc", ackCyc[0], 6);
      checkOutput("cont_second_id", ackIds[1], 2);
      checkOutput("cont_second_cyc", ackCyc[1], 22);
    end

    // Round-robin: pointer now at 3; ch0 and ch3 share key 3
    ackCyc.delete();
    ackIds.delete();
    req = 4'b1001;
    req_key[3:0]   = 4'h3;
    req_key[15:12] = 4'h3;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      applyStimulus();
      if (ack_valid) begin
        ackCyc.push_back(cyc);
        ackIds.push_back(int'(ack_id));
        req[ack_id] = 1'b0;
      end
    end
    checkOutput("rr_count", ackIds.size(), 2);
    if (ackIds.size() >= 2) begin
      checkOutput("rr_first_id", ackIds[0], 3);
      checkOutput("rr_second_id", ackIds[1], 0);
      checkOutput("rr_gap", ackCyc[1] - ackCyc[0], 16);
    end
    applyReset();

    // Wrap: ch3 key F asserted once the sweep has left F
    en = 1'b1;
    applyStimulus();
    req[3] = 1'b1;
    req_key[15:12] = 4'hF;
    n = 0;
    for (int cyc = 1; cyc <= 20 && n == 0; cyc++) begin
      applyStimulus();
      if (ack_valid) n = cyc;
    end
    checkOutput("wrap_steps", n, 16);
    checkOutput("wrap_ack", ack, 4'b1000);
    checkOutput("wrap_key_after", cur_key, 4'hE);
    req[3] = 1'b0;
    applyStimulus();
    applyReset();

    // Hold with en=0 at key 7, plus starvation on ch2
    en = 1'b1;
    repeat (8) applyStimulus();
    checkOutput("hold_key7", cur_key, 4'h7);
    en = 1'b0;
    req = 4'b1100;
    req_key[11:8]  = 4'h5;
    req_key[15:12] = 4'h7;
    for (int k = 1; k <= 63; k++) begin
      applyStimulus();
      checkOutput("hold_ack3", ack[3], k % 2);
      checkOutput("tmo2_count", timeout[2], (k == 63) ? 1 : 0);
    end
    checkOutput("tmo3_never", timeout[3], 0);
    req[2] = 1'b0;
    applyStimulus();
    checkOutput("tmo2_clear", timeout[2], 0);
    checkOutput("hold_ack3_low", ack[3], 0);
    applyStimulus();
    checkOutput("hold_ack3_high", ack[3], 1);
    #2;
    applyReset();

    // Random traffic against the model
    for (int cyc = 0; cyc < 600; cyc++) begin
      en = ($urandom_range(0, 9) < 7);
      for (int c = 0; c < NCH; c++) begin
        if (req[c]) begin
          if (mAckCh == c || $urandom_range(0, 49) == 0) req[c] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[c] = 1'b1;
          req_key[c*KW +: KW] = ($urandom_range(0, 2) == 0) ? 4'h5 : 4'($urandom_range(0, 15));
        end
      end
      applyStimulus();
    end
    checkOutput("scb_drain", scb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
